// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for round-robin arbiters: channel limits, index type,
// and a rotating-priority pick function that other arbiters can reuse.
package rr_arb_mux_pkg;

  localparam int MAX_CH = 16;

  typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

  typedef struct packed {
    logic    found;
    ch_idx_t idx;
  } rr_pick_t;

  // Scan valid starting at ptr, wrapping modulo MAX_CH. Callers with fewer
  // channels zero-extend valid; the unused high bits never match, so the
  // visiting order equals ptr..NUM_CH-1, 0..ptr-1.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] valid,
                                       input ch_idx_t ptr);
    rr_pick_t r;
    ch_idx_t  c;
    r = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      c = ptr + ch_idx_t'(i);
      if (!r.found && valid[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: purely combinational round-robin grant. Highest priority is
// the channel at ptr, then ascending with wrap. Produces a one-hot grant and
// the matching index; found=0 means no requester.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  logic [MAX_CH-1:0] valid_ext;
  rr_pick_t          pick;

  // Rotating-priority pick, then expand the index to a one-hot grant
  always_comb begin
    valid_ext = MAX_CH'(valid);
    pick      = rr_pick(valid_ext, ch_idx_t'(ptr));
    found     = pick.found;
    idx       = IDX_W'(pick.idx);
    grant     = pick.found ? (NUM_CH'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready mux with round-robin arbitration and a
// registered output stage (1 beat/cycle, no bubble on drain+load).
// Optional packet lock is enabled by defining RR_ARB_MUX_LOCK_EN: a channel
// that starts a packet keeps the grant until it sends a beat with last=1.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 32,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       in_valid_i,
  input  logic [NUM_CH*WIDTH-1:0] in_data_i,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last_i,
`endif
  output logic [NUM_CH-1:0]       in_ready_o,
  output logic                    out_valid_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [IDX_W-1:0]        out_ch_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  nxt_ptr;
  logic [NUM_CH-1:0] arb_valid;
  logic [NUM_CH-1:0] gnt;
  logic              found;
  logic              load_en;
  logic              take;

`ifdef RR_ARB_MUX_LOCK_EN
  logic              lock;
  logic [IDX_W-1:0]  lock_ch;
  logic              out_last_q;

  // While locked, only the locked channel is visible to the arbiter
  always_comb begin
    arb_valid = in_valid_i;
    if (lock) arb_valid = in_valid_i & (NUM_CH'(1) << lock_ch);
  end
`else
  // Per-beat arbitration: every requester is visible
  always_comb arb_valid = in_valid_i;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .valid (arb_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .found (found)
  );

  // Output register is free when empty or being drained this cycle; reset
  // masks ready so nothing is accepted during reset.
  always_comb begin
    load_en    = !out_valid_o || out_ready_i;
    take       = load_en && found && !rst_i;
    in_ready_o = take ? gnt : '0;
    nxt_ptr    = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  // Output stage and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ch_o    <= '0;
      rr_ptr      <= '0;
    end else if (load_en) begin
      if (found) begin
        out_valid_o <= 1'b1;
        out_data_o  <= in_data_i[gnt_idx*WIDTH +: WIDTH];
        out_ch_o    <= gnt_idx;
        rr_ptr      <= nxt_ptr;
      end else begin
        out_valid_o <= 1'b0;
      end
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  // Packet lock: set on a non-last beat, cleared by the last beat. The
  // pointer already advances to granted+1 on every beat, so the last beat
  // leaves it at lock_ch+1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock       <= 1'b0;
      lock_ch    <= '0;
      out_last_q <= 1'b0;
    end else if (take) begin
      lock       <= !in_last_i[gnt_idx];
      lock_ch    <= gnt_idx;
      out_last_q <= in_last_i[gnt_idx];
    end
  end

  assign out_last_o = out_last_q;
`else
  // Every beat is a whole packet; 0 while empty (including after reset)
  assign out_last_o = out_valid_o;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (NUM_CH=4, WIDTH=32): reset, fairness,
// skip/wrap, backpressure with drain scoreboard, mid-stream reset, and
// packet lock when RR_ARB_MUX_LOCK_EN is defined.
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_last;
  logic           out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int n_drain = 0;
  logic sb_on = 1'b0;
  logic [W-1:0] sb_exp [3];

  always #5 clk = ~clk;

  rr_arb_mux #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last_i   (in_last),
`endif
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dval(input int c, input int tag);
    return 32'hB000_0000 | W'(c << 8) | W'(tag);
  endfunction

  task automatic set_data(input int tag);
    for (int c = 0; c < N; c++) in_data[c*W +: W] = dval(c, tag);
  endtask

  // One cycle: drive at posedge+1, check ready before the edge, check the
  // output register after it. The drain scoreboard pops on each consumed beat.
  task automatic step(input string nm, input int tag, input logic ordy,
                      input logic [N-1:0] v, input logic [N-1:0] lst,
                      input logic [N-1:0] exp_rdy, input logic exp_vld,
                      input logic [1:0] exp_ch, input logic [W-1:0] exp_data,
                      input logic exp_last);
    in_valid  = v;
    in_last   = lst;
    out_ready = ordy;
    set_data(tag);
    #1;
    chk({nm, ".ready"}, 32'(in_ready), 32'(exp_rdy));
    if (sb_on && out_valid && out_ready) begin
      if (n_drain < 3) chk({nm, ".drain"}, out_data, sb_exp[n_drain]);
      else chk({nm, ".extra_drain"}, 32'(n_drain), 32'd2);
      n_drain++;
    end
    @(posedge clk); #1;
    chk({nm, ".vld"}, 32'(out_valid), 32'(exp_vld));
    if (exp_vld) begin
      chk({nm, ".ch"}, 32'(out_ch), 32'(exp_ch));
      chk({nm, ".data"}, out_data, exp_data);
      chk({nm, ".last"}, 32'(out_last), 32'(exp_last));
    end
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         ordy;
    logic [N-1:0] rdy;
    logic         vld;
    logic [1:0]   ch;
  } vec_t;

  vec_t tv [16];

  initial begin
    // fairness (0..3,0,1), skip/wrap with ch1+ch3 from ptr=2, idle drain,
    // stall, single requester
    tv[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tv[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    tv[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    tv[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tv[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[6]  = '{4'hA, 1'b1, 4'b1000, 1'b1, 2'd3};
    tv[7]  = '{4'hA, 1'b1, 4'b0010, 1'b1, 2'd1};
    tv[8]  = '{4'hA, 1'b1, 4'b1000, 1'b1, 2'd3};
    tv[9]  = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tv[10] = '{4'h4, 1'b0, 4'b0100, 1'b1, 2'd2};
    tv[11] = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd2};
    tv[12] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    tv[13] = '{4'h1, 1'b1, 4'b0001, 1'b1, 2'd0};
    tv[14] = '{4'h1, 1'b1, 4'b0001, 1'b1, 2'd0};
    tv[15] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd0};

    rst = 1'b1; in_valid = '1; in_last = '1; out_ready = 1'b1; set_data(0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst.ready", 32'(in_ready), 32'd0);
      chk("rst.vld",   32'(out_valid), 32'd0);
      chk("rst.ch",    32'(out_ch), 32'd0);
      chk("rst.data",  out_data, 32'd0);
      chk("rst.last",  32'(out_last), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      step($sformatf("vec%0d", i), 0, tv[i].ordy, tv[i].v, 4'hF, tv[i].rdy,
           tv[i].vld, tv[i].ch, dval(tv[i].ch, 0), 1'b1);

    // backpressure: ptr=1, 3 stalled cycles, then drain+load each edge
    sb_exp[0] = dval(1, 1); sb_exp[1] = dval(2, 5); sb_exp[2] = dval(3, 6);
    sb_on = 1'b1;
    step("bp_a", 1, 1'b1, 4'hF, 4'hF, 4'b0010, 1'b1, 2'd1, dval(1, 1), 1'b1);
    step("bp_b", 2, 1'b0, 4'hF, 4'hF, 4'b0000, 1'b1, 2'd1, dval(1, 1), 1'b1);
    step("bp_c", 3, 1'b0, 4'hF, 4'hF, 4'b0000, 1'b1, 2'd1, dval(1, 1), 1'b1);
    step("bp_d", 4, 1'b0, 4'hF, 4'hF, 4'b0000, 1'b1, 2'd1, dval(1, 1), 1'b1);
    step("bp_e", 5, 1'b1, 4'hF, 4'hF, 4'b0100, 1'b1, 2'd2, dval(2, 5), 1'b1);
    step("bp_f", 6, 1'b1, 4'hF, 4'hF, 4'b1000, 1'b1, 2'd3, dval(3, 6), 1'b1);
    step("bp_g", 7, 1'b1, 4'h0, 4'hF, 4'b0000, 1'b0, 2'd0, '0, 1'b0);
    sb_on = 1'b0;
    chk("bp.drained", 32'(n_drain), 32'd3);

    // reset while a beat is held under backpressure
    step("mr_a", 8, 1'b1, 4'hF, 4'hF, 4'b0001, 1'b1, 2'd0, dval(0, 8), 1'b1);
    step("mr_b", 9, 1'b0, 4'hF, 4'hF, 4'b0000, 1'b1, 2'd0, dval(0, 8), 1'b1);
    rst = 1'b1;
    #1;
    chk("mr.ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("mr.vld",  32'(out_valid), 32'd0);
    chk("mr.ch",   32'(out_ch), 32'd0);
    chk("mr.data", out_data, 32'd0);
    rst = 1'b0;

`ifdef RR_ARB_MUX_LOCK_EN
    // ch2 packet of 3 beats holds the grant against ch0, even while idle
    step("lk_a", 10, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, dval(2, 10), 1'b0);
    step("lk_b", 11, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, '0, 1'b0);
    step("lk_c", 12, 1'b1, 4'b0101, 4'b0000, 4'b0100, 1'b1, 2'd2, dval(2, 12), 1'b0);
    step("lk_d", 13, 1'b1, 4'b0101, 4'b0100, 4'b0100, 1'b1, 2'd2, dval(2, 13), 1'b1);
    step("lk_e", 14, 1'b1, 4'b0101, 4'b0001, 4'b0001, 1'b1, 2'd0, dval(0, 14), 1'b1);
`else
    // after reset the pointer is back at 0
    step("pr_a", 10, 1'b1, 4'b0101, 4'hF, 4'b0001, 1'b1, 2'd0, dval(0, 10), 1'b1);
    step("pr_b", 11, 1'b1, 4'b0101, 4'hF, 4'b0100, 1'b1, 2'd2, dval(2, 11), 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
